// File: rtl/timer_pkg.sv
// Shared constants for the timer interrupt responder: per-channel source
// offsets and the handshake FSM encoding.
package timer_pkg;

    localparam int SRCS_PER_CH = 3;

    localparam int SRC_CMIA = 0;
    localparam int SRC_CMIB = 1;
    localparam int SRC_OVI  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } irq_state_e;

    function automatic int src_index(input int ch, input int offset);
        return SRCS_PER_CH * ch + offset;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the index of the
// lowest set bit (lowest index = highest priority).
module irq_prio_enc #(
    parameter int NUM_SRC = 12,
    parameter int VEC_W   = 4
) (
    input  logic [NUM_SRC-1:0] req_i,
    output logic               found_o,
    output logic [VEC_W-1:0]   idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Interrupt responder for the 8-bit timer units: edge-captures CMIA/CMIB/OVI
// into pending flags, masks them with ier and hands one to the CPU by req/ack.
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int NUM_SRC = 3 * NUM_CH,
    parameter int VEC_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  cmia,
    input  logic [NUM_CH-1:0]  cmib,
    input  logic [NUM_CH-1:0]  ovi,
    input  logic               ier_we,
    input  logic [NUM_SRC-1:0] ier_wdata,
    input  logic [NUM_SRC-1:0] pend_clr,
    output logic               irq_req,
    output logic [VEC_W-1:0]   irq_vec,
    input  logic               irq_ack,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] ier,
    output logic [1:0]         dbg_state
);

    // Handshake: irq_req stays high with irq_vec stable until irq_ack is seen
    // high at a rising edge; irq_ack outside REQ is ignored.

    logic [NUM_SRC-1:0] src_in;
    logic [NUM_SRC-1:0] src_prev_q;
    logic               armed_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] ier_q, ier_d;
    logic               found;
    logic [VEC_W-1:0]   found_idx;
    irq_state_e         state_q;
    logic               irq_req_q;
    logic [VEC_W-1:0]   irq_vec_q;
    logic               ack_fire;

    always_comb begin
        src_in = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            src_in[src_index(c, SRC_CMIA)] = cmia[c];
            src_in[src_index(c, SRC_CMIB)] = cmib[c];
            src_in[src_index(c, SRC_OVI)]  = ovi[c];
        end
    end

    // The first edge after reset only primes src_prev, so a level that was
    // already high across reset is not mistaken for a fresh event.
    assign rise     = armed_q ? (src_in & ~src_prev_q) : '0;
    assign ack_fire = (state_q == REQ) && irq_ack;

    always_comb begin
        ack_clr = '0;
        if (ack_fire) begin
            ack_clr[irq_vec_q] = 1'b1;
        end
    end

    // A set from a rising edge wins over any clear in the same cycle.
    assign pending_d = (pending_q & ~(pend_clr | ack_clr)) | rise;
    assign ier_d     = ier_we ? ier_wdata : ier_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_prev_q <= '0;
            armed_q    <= 1'b0;
            pending_q  <= '0;
            ier_q      <= '0;
        end else begin
            src_prev_q <= src_in;
            armed_q    <= 1'b1;
            pending_q  <= pending_d;
            ier_q      <= ier_d;
        end
    end

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) u_prio_enc (
        .req_i   (pending_q & ier_q),
        .found_o (found),
        .idx_o   (found_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
            irq_vec_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q   <= REQ;
                        irq_req_q <= 1'b1;
                        irq_vec_q <= found_idx;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state_q   <= DONE;
                        irq_req_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req   = irq_req_q;
    assign irq_vec   = irq_vec_q;
    assign pending   = pending_q;
    assign ier       = ier_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: reset, single event, priority, masking,
// set-wins on ack and reset in the middle of a handshake.
module tb_timer_irq_ctrl;

    localparam int NUM_CH  = 4;
    localparam int NUM_SRC = 12;
    localparam int VEC_W   = 4;

    logic               clk;
    logic               rst_n;
    logic [NUM_CH-1:0]  cmia;
    logic [NUM_CH-1:0]  cmib;
    logic [NUM_CH-1:0]  ovi;
    logic               ier_we;
    logic [NUM_SRC-1:0] ier_wdata;
    logic [NUM_SRC-1:0] pend_clr;
    logic               irq_req;
    logic [VEC_W-1:0]   irq_vec;
    logic               irq_ack;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] ier;
    logic [1:0]         dbg_state;

    int total_cnt = 0;
    int bad_cnt   = 0;

    timer_irq_ctrl #(
        .NUM_CH  (NUM_CH),
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmia      (cmia),
        .cmib      (cmib),
        .ovi       (ovi),
        .ier_we    (ier_we),
        .ier_wdata (ier_wdata),
        .pend_clr  (pend_clr),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .pending   (pending),
        .ier       (ier),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ier(input logic [NUM_SRC-1:0] val);
        ier_we    = 1'b1;
        ier_wdata = val;
        tick();
        ier_we    = 1'b0;
        ier_wdata = '0;
    endtask

    task automatic ack_once();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmia      = '0;
        cmib      = '0;
        ovi       = '0;
        ier_we    = 1'b0;
        ier_wdata = '0;
        pend_clr  = '0;
        irq_ack   = 1'b0;

        // 1. reset
        tick();
        tick();
        check("rst_req", 32'(irq_req), 32'd0);
        check("rst_pend", 32'(pending), 32'h000);
        check("rst_ier", 32'(ier), 32'h000);
        check("rst_vec", 32'(irq_vec), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick();

        // 2. single event
        write_ier(12'hFFF);
        check("t2_ier", 32'(ier), 32'hFFF);
        cmia = 4'b0001;
        tick();
        check("t2_pend_k", 32'(pending), 32'h001);
        check("t2_req_k", 32'(irq_req), 32'd0);
        cmia = 4'b0000;
        tick();
        check("t2_req_k1", 32'(irq_req), 32'd1);
        check("t2_vec_k1", 32'(irq_vec), 32'd0);
        check("t2_state_req", 32'(dbg_state), 32'd1);
        ack_once();
        check("t2_req_ack", 32'(irq_req), 32'd0);
        check("t2_pend_ack", 32'(pending), 32'h000);
        check("t2_state_done", 32'(dbg_state), 32'd2);
        tick();
        check("t2_state_idle", 32'(dbg_state), 32'd0);

        // 3. priority: cmib[1] (src 4) beats ovi[3] (src 11)
        cmib = 4'b0010;
        ovi  = 4'b1000;
        tick();
        check("t3_pend", 32'(pending), 32'h810);
        cmib = '0;
        ovi  = '0;
        tick();
        check("t3_req1", 32'(irq_req), 32'd1);
        check("t3_vec1", 32'(irq_vec), 32'd4);
        ack_once();
        check("t3_req_a", 32'(irq_req), 32'd0);
        check("t3_pend_a", 32'(pending), 32'h800);
        tick();
        check("t3_req_gap", 32'(irq_req), 32'd0);
        tick();
        check("t3_req2", 32'(irq_req), 32'd1);
        check("t3_vec2", 32'(irq_vec), 32'd11);
        // request must survive mask change and clear of the latched source
        pend_clr  = 12'h800;
        ier_we    = 1'b1;
        ier_wdata = 12'h000;
        tick();
        pend_clr  = '0;
        ier_we    = 1'b0;
        check("t3_hold_req", 32'(irq_req), 32'd1);
        check("t3_hold_vec", 32'(irq_vec), 32'd11);
        check("t3_hold_pend", 32'(pending), 32'h000);
        ack_once();
        check("t3_req_end", 32'(irq_req), 32'd0);
        check("t3_pend_end", 32'(pending), 32'h000);
        tick();

        // 4. masking (ier is 0 from the write above)
        check("t4_ier0", 32'(ier), 32'h000);
        cmia = 4'b0100;
        tick();
        check("t4_pend", 32'(pending), 32'h040);
        cmia = '0;
        tick();
        tick();
        check("t4_req_masked", 32'(irq_req), 32'd0);
        // ack outside REQ must be ignored
        ack_once();
        check("t4_ack_ignored", 32'(pending), 32'h040);
        write_ier(12'h040);
        check("t4_req_w", 32'(irq_req), 32'd0);
        tick();
        check("t4_req_w1", 32'(irq_req), 32'd1);
        check("t4_vec_w1", 32'(irq_vec), 32'd6);
        ack_once();
        check("t4_pend_end", 32'(pending), 32'h000);
        tick();

        // 5. set wins over ack-clear
        write_ier(12'hFFF);
        cmia = 4'b0001;
        tick();
        cmia = 4'b0000;
        tick();
        check("t5_req", 32'(irq_req), 32'd1);
        check("t5_vec", 32'(irq_vec), 32'd0);
        cmia    = 4'b0001;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        cmia    = 4'b0000;
        check("t5_req_ack", 32'(irq_req), 32'd0);
        check("t5_pend_kept", 32'(pending), 32'h001);
        tick();
        check("t5_req_gap", 32'(irq_req), 32'd0);
        tick();
        check("t5_req_again", 32'(irq_req), 32'd1);
        check("t5_vec_again", 32'(irq_vec), 32'd0);
        ack_once();
        check("t5_pend_end", 32'(pending), 32'h000);
        tick();

        // pend_clr of a pending bit, then of a non-pending bit
        ovi = 4'b0001;
        tick();
        ovi = '0;
        check("clr_pend_set", 32'(pending), 32'h004);
        pend_clr = 12'h004;
        tick();
        pend_clr = 12'h010;
        check("clr_pend_pulse", 32'(pending), 32'h000);
        tick();
        pend_clr = '0;
        check("clr_nonpend", 32'(pending), 32'h000);
        tick();

        // 6. reset mid-handshake with a held-high input
        cmia = 4'b0001;
        cmib = 4'b0001;
        tick();
        cmib = '0;
        check("t6_pend", 32'(pending), 32'h003);
        tick();
        check("t6_req", 32'(irq_req), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_req", 32'(irq_req), 32'd0);
        check("t6_rst_pend", 32'(pending), 32'h000);
        check("t6_rst_state", 32'(dbg_state), 32'd0);
        tick();
        check("t6_held1", 32'(pending), 32'h000);
        tick();
        check("t6_held2", 32'(pending), 32'h000);
        cmia = 4'b0000;
        tick();
        cmia = 4'b0001;
        tick();
        check("t6_rearm", 32'(pending), 32'h001);
        check("t6_req_masked", 32'(irq_req), 32'd0);
        cmia = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
